// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage load/store unit for an RV32I pipeline.
// Runs one req/gnt/rvalid bus transaction per load or store, formats store
// data and byte enables, and extracts and extends load data.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When it is defined, a
// misaligned access is trapped. When it is undefined, the offending low
// address bits are forced to zero.
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        rden_i,
  input  logic        wren_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] sdata_i,
  input  logic [2:0]  rwsel_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic [31:0] ldata_o,
  output logic        stall_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      r_state, w_next;
  logic        r_req, r_we;
  logic [31:0] r_addr, r_wdata, r_ldata;
  logic [3:0]  r_be;
  logic [1:0]  r_off, r_sz;
  logic        r_uns;

  logic        w_op, w_byte, w_half, w_trap;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_sh, w_ext;

  assign w_op   = rden_i | wren_i;
  assign w_byte = (rwsel_i[1:0] == 2'b00);
  assign w_half = (rwsel_i[1:0] == 2'b01);

  // Byte offset with misaligned low bits dropped. In trap mode a misaligned
  // op never reaches the bus, so the same offset works in both builds.
  assign w_off = w_byte ? addr_i[1:0] : (w_half ? {addr_i[1], 1'b0} : 2'b00);

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_mis;
  logic r_misalign;
  assign w_mis  = (w_half & addr_i[0]) | (!w_byte & !w_half & (|addr_i[1:0]));
  assign w_trap = w_mis;

  // Trap flag: raised for the DONE cycle of a misaligned op only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_misalign <= 1'b0;
    else if (r_state == S_IDLE && w_op && w_trap) r_misalign <= 1'b1;
    else                                     r_misalign <= 1'b0;
  end
  assign misalign_o = r_misalign;
`else
  assign w_trap     = 1'b0;
  assign misalign_o = 1'b0;
`endif

  // Store formatting: replicate data across lanes, enable the addressed bytes.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = sdata_i;
    if (wren_i) begin
      if (w_byte) begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{sdata_i[7:0]}};
      end else if (w_half) begin
        w_be    = 4'b0011 << w_off;
        w_wdata = {2{sdata_i[15:0]}};
      end else begin
        w_be    = 4'b1111;
      end
    end
  end

  // Load extraction: shift the addressed lane down, then extend.
  assign w_sh = bus_rdata_i >> {r_off, 3'b000};
  always_comb begin
    w_ext = w_sh;
    case (r_sz)
      2'b00:   w_ext = {{24{w_sh[7]  & ~r_uns}}, w_sh[7:0]};
      2'b01:   w_ext = {{16{w_sh[15] & ~r_uns}}, w_sh[15:0]};
      default: w_ext = w_sh;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and pipeline stall.
  always_comb begin
    w_next  = r_state;
    stall_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall_o = w_op;
        if (w_op) w_next = w_trap ? S_DONE : S_REQ;
      end
      S_REQ: begin
        stall_o = 1'b1;
        if (bus_gnt_i) w_next = (r_we || bus_rvalid_i) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        stall_o = 1'b1;
        if (bus_rvalid_i) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Bus request fields and load result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_ldata <= '0;
      r_off   <= '0;
      r_sz    <= '0;
      r_uns   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_op) begin
          if (w_trap) begin
            r_ldata <= '0;
          end else begin
            r_req   <= 1'b1;
            r_we    <= wren_i;
            r_addr  <= {addr_i[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_off   <= w_off;
            r_sz    <= rwsel_i[1:0];
            r_uns   <= rwsel_i[2];
          end
        end
        S_REQ: if (bus_gnt_i) begin
          r_req <= 1'b0;
          if (!r_we && bus_rvalid_i) r_ldata <= w_ext;
        end
        S_WAIT: if (bus_rvalid_i) r_ldata <= w_ext;
        default: ;
      endcase
    end
  end

  assign bus_req_o   = r_req;
  assign bus_we_o    = r_we;
  assign bus_addr_o  = r_addr;
  assign bus_be_o    = r_be;
  assign bus_wdata_o = r_wdata;
  assign ldata_o     = r_ldata;

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-stage load/store unit. Consumes the EX/MEM pipeline register outputs and runs one data-memory transaction per load or store over a req/gnt/rvalid bus. It formats store data and byte enables, and extracts and extends load data for the MEM/WB register. It stalls the pipeline with `stall_o` while a transaction is in flight.

## Interface
- No parameters; all widths are fixed for RV32I.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rden_i` in 1: load in MEM stage.
- `wren_i` in 1: store in MEM stage; wins if `rden_i` is also high.
- `addr_i` in 32: effective address (ALU result).
- `sdata_i` in 32: store source register value.
- `rwsel_i` in 3: funct3 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 act as W.
- `bus_req_o` out 1: request valid.
- `bus_we_o` out 1: 1 = write.
- `bus_addr_o` out 32: word address, `{addr_i[31:2],2'b00}`.
- `bus_be_o` out 4: byte enables (writes only; 4'b0000 on reads).
- `bus_wdata_o` out 32: lane-replicated store data.
- `bus_gnt_i` in 1: request accepted this cycle.
- `bus_rvalid_i` in 1: read data valid.
- `bus_rdata_i` in 32: read data word.
- `ldata_o` out 32: extended load result.
- `stall_o` out 1: hold PC and IF/ID/ID_EX/EX_MEM registers.
- `misalign_o` out 1: misaligned-access flag (see Configuration).

## Operation
- States: IDLE, REQ, WAIT, DONE. The state register is reset asynchronously to IDLE.
- IDLE: with `rden_i|wren_i`, latch op, address, size and formatted data, then go to REQ. With no op, stay in IDLE.
- REQ:
  - `bus_req_o`=1 with stable addr/we/be/wdata until `bus_gnt_i`.
  - Store + gnt → DONE.
  - Load + gnt → WAIT, or → DONE if `bus_rvalid_i` arrives in the same cycle.
- WAIT: on `bus_rvalid_i`, capture the extended data into `ldata_o` and go to DONE.
- DONE: one cycle, then IDLE.
- `stall_o` is combinational:
  - 1 in IDLE when an op is present.
  - 1 in REQ and WAIT.
  - 0 in DONE and in IDLE with no op.
- Store formatting:
  - SB: wdata `{4{sdata_i[7:0]}}`, be `4'b0001<<addr[1:0]`.
  - SH: wdata `{2{sdata_i[15:0]}}`, be `4'b0011<<{addr[1],1'b0}`.
  - SW: wdata `sdata_i`, be `4'b1111`.
- Load extraction: `rdata>>(8*addr[1:0])`, then sign-extend (B/H) or zero-extend (BU/HU) from bit 7/15. W passes through.
- `ldata_o` holds its value until the next load capture. Stores do not change it.
- `bus_rvalid_i` outside REQ/WAIT is ignored. `bus_gnt_i` outside REQ is ignored.

## Timing
- All outputs are registered except `stall_o`.
- Reset values: `bus_req_o`=0, `bus_we_o`=0, `bus_addr_o`=0, `bus_be_o`=0, `bus_wdata_o`=0, `ldata_o`=0, `misalign_o`=0. `stall_o`=0 after reset because the state is IDLE with no op.
- Op presented at cycle 0 (IDLE): `bus_req_o` high at cycle 1.
- Minimum latency is 3 cycles: gnt at cycle 1 gives DONE at cycle 2. For loads this requires rvalid at cycle 1 as well.
- Each extra gnt or rvalid wait cycle adds one cycle of stall.
- Back-to-back ops: after DONE the FSM passes through IDLE for one cycle before issuing the next request.
- Reset mid-transaction:
  - Immediately drops `bus_req_o` and returns to IDLE.
  - A late rvalid for the aborted request is ignored.
  - `ldata_o` is cleared.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - In IDLE, a misaligned op (H/HU/SH with `addr[0]`=1; W/SW with `addr[1:0]`≠0) issues no bus request and goes directly to DONE.
  - In that DONE cycle, `misalign_o`=1 and `ldata_o`=0.
  - `misalign_o` is otherwise 0.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Offending low address bits are forced to 0 (halfword: bit 0; word: bits 1:0) and the access proceeds normally.
  - `misalign_o` is tied to 0.

## Test plan
- SB addr 0x1003, sdata 0xAABBCCDD, gnt at cycle 1 → be=4'b1000, wdata=0xDDDDDDDD, `stall_o` high cycles 0–1 and low at cycle 2.
- LH addr 0x2002, gnt at cycle 1, rvalid at cycle 3 with rdata 0x8001_1234 → `ldata_o`=0xFFFF8001. Repeat as LHU → `ldata_o`=0x00008001.
- LW, gnt withheld 4 cycles, then gnt+rvalid together with 0xDEADBEEF → `stall_o` high 6 cycles, `ldata_o`=0xDEADBEEF; the `bus_addr_o`/`bus_be_o` request fields stay stable throughout.
- SW addr 0x3002:
  - With macro → no `bus_req_o`, `misalign_o`=1 for one cycle.
  - Without macro → bus_addr=0x3000, be=4'b1111.
- Assert `rst` in WAIT, then pulse rvalid with 0x12345678 after reset release → FSM in IDLE, `ldata_o`=0, `stall_o`=0.
- `rden_i`=`wren_i`=1, SW addr 0x40 → write transaction with we=1; `ldata_o` unchanged.
